// File: rtl/aoc_day1_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : aoc_day1_cmd_parser
// Brief    : ASCII line parser ("L68\n") -> rotation commands on valid/ready.
//            Define AOC_CMD_MULTISEP_EN to also accept ',' and ' ' as terminators.
// Revision : 1.0 - initial release
// ============================================================================
module aoc_day1_cmd_parser #(
    parameter int DATA_W   = 32,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic                cmd_ready,
    output logic                cmd_valid,
    output logic                dir_r,
    output logic [DATA_W-1:0]   data_out,
    output logic [31:0]         cmd_count,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIR  = 2'd1,
        S_NUM  = 2'd2,
        S_SKIP = 2'd3
    } state_t;

    localparam logic [7:0] C_LF    = 8'h0A;
    localparam logic [7:0] C_CR    = 8'h0D;
    localparam logic [7:0] C_L     = 8'h4C;
    localparam logic [7:0] C_R     = 8'h52;
    localparam int         C_ACC_W = DATA_W + 4;

    state_t                r_state;
    logic                  r_dir_lat;
    logic [DATA_W-1:0]     r_acc;
    logic                  r_cmd_valid;
    logic                  r_dir;
    logic [DATA_W-1:0]     r_data;
    logic [31:0]           r_cmd_count;
    logic                  r_err;
    logic [ERRCNT_W-1:0]   r_err_count;

    logic                  w_byte_fire;
    logic                  w_cmd_fire;
    logic                  w_is_digit;
    logic                  w_is_dir;
    logic                  w_is_cr;
    logic                  w_is_term;
    logic [3:0]            w_digit;
    logic [C_ACC_W-1:0]    w_acc_ext;
    logic [C_ACC_W-1:0]    w_acc_next;
    logic                  w_acc_ovf;
    logic                  w_line_err;

    assign byte_ready  = !r_cmd_valid || cmd_ready;
    assign w_byte_fire = byte_valid && byte_ready;
    assign w_cmd_fire  = r_cmd_valid && cmd_ready;

    assign w_is_digit  = (byte_in >= 8'h30) && (byte_in <= 8'h39);
    assign w_is_dir    = (byte_in == C_L) || (byte_in == C_R);
    assign w_is_cr     = (byte_in == C_CR);
    assign w_digit     = byte_in[3:0];

`ifdef AOC_CMD_MULTISEP_EN
    assign w_is_term   = (byte_in == C_LF) || (byte_in == 8'h2C) || (byte_in == 8'h20);
`else
    assign w_is_term   = (byte_in == C_LF);
`endif

    // acc*10 + digit, widened so an overflow shows up in the top nibble
    assign w_acc_ext   = {4'b0000, r_acc};
    assign w_acc_next  = (w_acc_ext << 3) + (w_acc_ext << 1) + C_ACC_W'(w_digit);
    assign w_acc_ovf   = |w_acc_next[C_ACC_W-1:DATA_W];

    // A line is faulted at most once: the faulting byte always leaves DIR/NUM
    // for SKIP or IDLE, and SKIP itself never flags.
    assign w_line_err  = w_byte_fire && (
                           ((r_state == S_IDLE) && !w_is_dir && !w_is_term && !w_is_cr) ||
                           ((r_state == S_DIR)  && !w_is_digit && !w_is_cr) ||
                           ((r_state == S_NUM)  && ((w_is_digit && w_acc_ovf) ||
                                                    (!w_is_digit && !w_is_cr && !w_is_term))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dir_lat   <= 1'b0;
            r_acc       <= '0;
            r_cmd_valid <= 1'b0;
            r_dir       <= 1'b0;
            r_data      <= '0;
            r_cmd_count <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_cmd_valid <= 1'b0;
                r_dir       <= 1'b0;
                r_data      <= '0;
                r_cmd_count <= r_cmd_count + 32'd1;
            end

            if (w_line_err) begin
                r_err <= 1'b1;
                if (r_err_count != {ERRCNT_W{1'b1}}) begin
                    r_err_count <= r_err_count + ERRCNT_W'(1);
                end
            end

            if (w_byte_fire) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_is_dir) begin
                            r_dir_lat <= (byte_in == C_R);
                            r_acc     <= '0;
                            r_state   <= S_DIR;
                        end else if (!w_is_term && !w_is_cr) begin
                            r_state   <= S_SKIP;
                        end
                    end
                    S_DIR: begin
                        if (w_is_digit) begin
                            r_acc   <= DATA_W'(w_digit);
                            r_state <= S_NUM;
                        end else if (w_is_term) begin
                            r_state <= S_IDLE;
                        end else if (!w_is_cr) begin
                            r_state <= S_SKIP;
                        end
                    end
                    S_NUM: begin
                        if (w_is_digit) begin
                            if (w_acc_ovf) begin
                                r_state <= S_SKIP;
                            end else begin
                                r_acc   <= w_acc_next[DATA_W-1:0];
                            end
                        end else if (w_is_term) begin
                            // overrides the clear above when a command is taken this cycle
                            r_cmd_valid <= 1'b1;
                            r_dir       <= r_dir_lat;
                            r_data      <= r_acc;
                            r_state     <= S_IDLE;
                        end else if (!w_is_cr) begin
                            r_state <= S_SKIP;
                        end
                    end
                    S_SKIP: begin
                        if (w_is_term) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign dir_r     = r_dir;
    assign data_out  = r_data;
    assign cmd_count = r_cmd_count;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_aoc_day1_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_aoc_day1_cmd_parser
// Brief    : Line-level reference model + directed and random byte streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aoc_day1_cmd_parser;

    localparam int DATA_W   = 32;
    localparam int ERRCNT_W = 16;
    localparam longint unsigned MAXV = (64'd1 << DATA_W) - 64'd1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          byte_in = 8'h00;
    logic                byte_valid = 1'b0;
    logic                byte_ready;
    logic                cmd_ready = 1'b1;
    logic                cmd_valid;
    logic                dir_r;
    logic [DATA_W-1:0]   data_out;
    logic [31:0]         cmd_count;
    logic                err;
    logic [ERRCNT_W-1:0] err_count;

    always #5 clk = ~clk;

    aoc_day1_cmd_parser #(.DATA_W(DATA_W), .ERRCNT_W(ERRCNT_W)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
        .dir_r(dir_r), .data_out(data_out), .cmd_count(cmd_count),
        .err(err), .err_count(err_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: what the outputs must be after the next edge
    bit                m_valid = 0;
    bit                m_dir   = 0;
    logic [DATA_W-1:0] m_data  = '0;
    logic [31:0]       m_count = '0;
    int                m_errs  = 0;
    byte unsigned      m_line[$];
    bit                m_accepted = 0;

    logic [DATA_W:0]   got_q[$];
    bit                pre_ready_chk = 0;
    int                rdy_mode = 0;
    int                gap_pct  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_term(input logic [7:0] b);
`ifdef AOC_CMD_MULTISEP_EN
        return (b == 8'h0A) || (b == 8'h2C) || (b == 8'h20);
`else
        return (b == 8'h0A);
`endif
    endfunction

    // Judge a whole line (CRs already stripped): 0 = nothing, 1 = command, 2 = error
    function automatic void eval_line(output int kind, output bit d, output logic [DATA_W-1:0] v);
        longint unsigned acc = 0;
        kind = 0; d = 0; v = '0;
        if (m_line.size() == 0) return;
        if (m_line[0] != 8'h4C && m_line[0] != 8'h52) begin kind = 2; return; end
        if (m_line.size() < 2) begin kind = 2; return; end
        for (int i = 1; i < m_line.size(); i++) begin
            if (m_line[i] < 8'h30 || m_line[i] > 8'h39) begin kind = 2; return; end
            acc = acc * 10 + (longint'(m_line[i]) - 48);
            if (acc > MAXV) begin kind = 2; return; end
        end
        kind = 1;
        d    = (m_line[0] == 8'h52);
        v    = acc[DATA_W-1:0];
    endfunction

    task automatic model_edge(input logic bv, input logic [7:0] b, input logic cr);
        int k; bit d; logic [DATA_W-1:0] v;
        m_accepted = bv && (!m_valid || cr);
        if (m_valid && cr) begin
            m_valid = 0; m_dir = 0; m_data = '0; m_count = m_count + 32'd1;
        end
        if (m_accepted) begin
            if (is_term(b)) begin
                eval_line(k, d, v);
                m_line.delete();
                if (k == 1) begin
                    m_valid = 1; m_dir = d; m_data = v;
                end else if (k == 2 && m_errs < (1 << ERRCNT_W) - 1) begin
                    m_errs++;
                end
            end else if (b != 8'h0D) begin
                m_line.push_back(b);
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_dir = 0; m_data = '0; m_count = '0; m_errs = 0;
        m_line.delete();
        got_q.delete();
    endtask

    // Compare process: outputs against model every cycle
    always @(posedge clk) begin
        #1;
        chk("cmd_valid", cmd_valid, m_valid);
        chk("dir_r", dir_r, m_dir);
        chk("data_out", data_out, m_data);
        chk("byte_ready", byte_ready, !m_valid || cmd_ready);
        chk("cmd_count", cmd_count, m_count);
        if (m_line.size() == 0) begin
            chk("err", err, m_errs != 0);
            chk("err_count", err_count, m_errs);
        end
    end

    task automatic step(input logic bv, input logic [7:0] b, input logic cr);
        @(negedge clk);
        byte_valid = bv; byte_in = b; cmd_ready = cr;
        #1;
        if (pre_ready_chk) begin
            chk("ready_same_cycle", byte_ready, 1'b1);
            pre_ready_chk = 0;
        end
        if (cmd_valid && cmd_ready) got_q.push_back({dir_r, data_out});
        model_edge(bv, b, cr);
        @(posedge clk);
    endtask

    function automatic logic pick_rdy();
        if (rdy_mode == 0) return 1'b1;
        return ($urandom_range(99) < 60);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        do begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct)
                step(1'b0, 8'($urandom), pick_rdy());
            step(1'b1, b, pick_rdy());
            n++;
        end while (!m_accepted && n < 300);
        if (!m_accepted) begin
            total++; bad++;
            $display("FAIL byte_timeout: byte %0h not accepted within %0d tries", b, n);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain();
        repeat (3) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; byte_valid = 1'b0; cmd_ready = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_cmd(input string name, input int idx, input bit d, input logic [DATA_W-1:0] v);
        if (idx < got_q.size()) chk(name, got_q[idx], {d, v});
        else begin
            total++; bad++;
            $display("FAIL %s: command %0d missing, got %0d commands", name, idx, got_q.size());
        end
    endtask

    function automatic string gen_line();
        string s = "";
        string dch;
        longint unsigned v = 0;
        int k = $urandom_range(9);
        dch = ($urandom_range(1) == 1) ? "R" : "L";
        case (k)
            0, 1, 2, 3: begin
                case ($urandom_range(3))
                    0: v = $urandom_range(999);
                    1: v = longint'($urandom);
                    2: v = MAXV - 2 + longint'($urandom_range(4));
                    default: v = $urandom_range(9);
                endcase
                s = dch;
                if ($urandom_range(3) == 0) s = {s, "00"};
                s = {s, $sformatf("%0d", v)};
            end
            4: s = "";
            5: s = dch;
            6: s = $sformatf("X%0d", $urandom_range(99));
            7: s = {dch, "4a5"};
            8: for (int i = 0; i < 1 + $urandom_range(5); i++)
                   s = $sformatf("%s%c", s, 8'($urandom_range(255, 1)));
            default: s = $sformatf("%s%0d\r%0d", dch, $urandom_range(99), $urandom_range(9));
        endcase
        if ($urandom_range(3) == 0) s = {s, "\r"};
        return {s, "\n"};
    endfunction

    initial begin
        int  exp_d[10];
        bit  exp_r[10];
        exp_d = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};
        exp_r = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};

        // Reset state
        do_reset();
        @(posedge clk); #2;
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_byte_ready", byte_ready, 1'b1);
        chk("rst_data_out", data_out, 0);
        chk("rst_cmd_count", cmd_count, 0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_count", err_count, 0);

        // Example puzzle input
        send_str("L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n");
        drain();
        chk("ex_ncmds", got_q.size(), 10);
        for (int i = 0; i < 10; i++) chk_cmd("ex_cmd", i, exp_r[i], exp_d[i]);
        chk("ex_cmd_count", cmd_count, 10);
        chk("ex_err", err, 1'b0);

        // Backpressure
        do_reset();
        send_str("R48\n");
        repeat (3) begin
            step(1'b1, 8'h4C, 1'b0);
            #1;
            chk("bp_valid", cmd_valid, 1'b1);
            chk("bp_data", data_out, 48);
            chk("bp_ready", byte_ready, 1'b0);
        end
        pre_ready_chk = 1;
        step(1'b1, 8'h4C, 1'b1);
        send_str("5\n");
        drain();
        chk("bp_ncmds", got_q.size(), 2);
        chk_cmd("bp_cmd0", 0, 1'b1, 48);
        chk_cmd("bp_cmd1", 1, 1'b0, 5);

        // Malformed lines
        do_reset();
        send_str("X12\nL\nR4a5\nL7\n");
        drain();
        chk("bad_ncmds", got_q.size(), 1);
        chk_cmd("bad_cmd", 0, 1'b0, 7);
        chk("bad_err", err, 1'b1);
        chk("bad_err_count", err_count, 3);

        // CRLF and blank lines
        do_reset();
        send_str("\r\n\nR99\r\n");
        drain();
        chk("crlf_ncmds", got_q.size(), 1);
        chk_cmd("crlf_cmd", 0, 1'b1, 99);
        chk("crlf_err", err, 1'b0);

        // Accumulator boundary
        do_reset();
        send_str("L4294967296\n");
        drain();
        chk("ovf_ncmds", got_q.size(), 0);
        chk("ovf_err_count", err_count, 1);
        send_str("R4294967295\n");
        drain();
        chk_cmd("max_cmd", 0, 1'b1, 32'hFFFF_FFFF);
        chk("lead0_prep", got_q.size(), 1);
        send_str("R007\n");
        drain();
        chk_cmd("lead0_cmd", 1, 1'b1, 7);

        // Reset with a pending command, then mid-line
        do_reset();
        send_str("L9\n");
        step(1'b1, 8'h52, 1'b0);
        do_reset();
        chk("rst_pend_valid", cmd_valid, 1'b0);
        send_str("R12");
        do_reset();
        chk("rst_mid_count", cmd_count, 0);
        send_str("L3\n");
        drain();
        chk("rst_mid_ncmds", got_q.size(), 1);
        chk_cmd("rst_mid_cmd", 0, 1'b0, 3);
        chk("rst_mid_cmd_count", cmd_count, 1);
        chk("rst_mid_err", err_count, 0);

        // Alternate separators
        do_reset();
        send_str("L68,R48 L5,");
        drain();
`ifdef AOC_CMD_MULTISEP_EN
        chk("sep_ncmds", got_q.size(), 3);
        chk_cmd("sep_cmd0", 0, 1'b0, 68);
        chk_cmd("sep_cmd1", 1, 1'b1, 48);
        chk_cmd("sep_cmd2", 2, 1'b0, 5);
        chk("sep_err", err, 1'b0);
`else
        chk("sep_ncmds", got_q.size(), 0);
        chk("sep_err", err, 1'b1);
        chk("sep_err_count", err_count, 1);
`endif

        // Random lines with random gaps and backpressure
        do_reset();
        rdy_mode = 1;
        gap_pct  = 20;
        for (int i = 0; i < 250; i++) send_str(gen_line());
        rdy_mode = 0;
        gap_pct  = 0;
        drain();
        chk("rand_ncmds", got_q.size(), m_count);
        chk("rand_cmd_count", cmd_count, m_count);
        chk("rand_err_count", err_count, m_errs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
